// File: rtl/nested_struct_pkg.sv
// Shared types and helpers for the nested-struct record link.
// The transmit side packs outer_t = {inner_t hdr, data} MSB-first into beats.
package nested_struct_pkg;

  localparam int unsigned HDR_W         = 4;
  localparam int unsigned DEF_PAYLOAD_W = 20;

  // Inner header carried in the top bits of every record.
  typedef struct packed {
    logic       flag;
    logic [2:0] kind;
  } inner_t;

  // Template outer record at the default payload width; modules with a
  // different PAYLOAD_W build the same layout locally.
  typedef struct packed {
    inner_t                   hdr;
    logic [DEF_PAYLOAD_W-1:0] data;
  } outer_t;

  // Number of beats needed to carry one record.
  function automatic int unsigned calc_nbeats(input int unsigned rec_w,
                                              input int unsigned beat_w);
    return (rec_w + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/nested_struct_out_reg.sv
// One-entry valid/ready holding register for reassembled records.
// The producer only asserts load_i when the slot is empty or draining this cycle.
module nested_struct_out_reg #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Load wins over drain so a simultaneous drain+load leaves no bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/nested_struct_deser.sv
// Beat-to-record deserializer for the nested-struct link.
// Optional framing check: define NESTED_STRUCT_DESER_FRAME_CHECK_EN to validate
// s_last on every beat and raise a sticky err on mismatch.
// Assumes a record spans at least two beats.
module nested_struct_deser
  import nested_struct_pkg::*;
#(
  parameter int unsigned BEAT_W    = 8,
  parameter int unsigned PAYLOAD_W = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [HDR_W+PAYLOAD_W-1:0] m_rec,
  output logic                       err
);

  localparam int unsigned REC_W  = HDR_W + PAYLOAD_W;
  localparam int unsigned NBEATS = calc_nbeats(REC_W, BEAT_W);
  localparam int unsigned TOT_W  = NBEATS * BEAT_W;
  localparam int unsigned ACC_W  = TOT_W - BEAT_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NBEATS - 1);

  typedef struct packed {
    inner_t               hdr;
    logic [PAYLOAD_W-1:0] data;
  } rec_t;

  typedef enum logic [0:0] {StCollect, StLast} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TOT_W-1:0] frame;
  rec_t             rec;
  state_e           state;
  logic             beat_fire;
  logic             frame_bad;
  logic             load;

  // The phase is fully determined by the beat counter.
  assign state = (cnt_q == CntLast) ? StLast : StCollect;

  // Only the final beat can stall, and only against a full, non-draining output.
  assign s_ready   = !(state == StLast && m_valid && !m_ready);
  assign beat_fire = s_valid && s_ready;

  // Accumulated beats plus the current one; padding sits in the low bits.
  assign frame = {acc_q, s_data};
  assign rec   = rec_t'(frame[TOT_W-1 -: REC_W]);

`ifdef NESTED_STRUCT_DESER_FRAME_CHECK_EN
  logic err_q;

  assign frame_bad = beat_fire && (s_last != (state == StLast));

  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (frame_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_last;

  assign unused_last = s_last;
  assign frame_bad   = 1'b0;
  assign err         = 1'b0;
`endif

  assign load = beat_fire && (state == StLast) && !frame_bad;

  // Next-state for beat counter and accumulator; a bad frame resyncs to beat 0.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (frame_bad) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (beat_fire) begin
      if (state == StLast) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = frame[ACC_W-1:0];
      end
    end
  end

  // Beat counter and accumulator state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  nested_struct_out_reg #(
    .Width(REC_W)
  ) u_out_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .data_i (rec),
    .ready_i(m_ready),
    .valid_o(m_valid),
    .data_o (m_rec)
  );

endmodule

// File: tb/tb_nested_struct_deser.sv
`timescale 1ns/1ps
module tb_nested_struct_deser;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, s_last, m_valid, m_ready, err;
  logic [7:0]  s_data;
  logic [23:0] m_rec;

  // Second instance with a padded final beat (REC_W=20).
  logic        s2_valid, s2_ready, s2_last, m2_valid, m2_ready, err2;
  logic [7:0]  s2_data;
  logic [19:0] m2_rec;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          pops  = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  mbeats[$];
  logic        err_exp = 1'b0;
  bit          ready_rand = 1'b0;
  bit          gap_rand = 1'b0;
  logic        held_v = 1'b0;
  logic [23:0] held_val = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  nested_struct_deser dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_rec  (m_rec),
    .err    (err)
  );

  nested_struct_deser #(
    .BEAT_W   (8),
    .PAYLOAD_W(16)
  ) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s2_valid),
    .s_ready(s2_ready),
    .s_data (s2_data),
    .s_last (s2_last),
    .m_valid(m2_valid),
    .m_ready(m2_ready),
    .m_rec  (m2_rec),
    .err    (err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model + scoreboard: records are built from accepted beats
  // three at a time; outputs are popped in order whenever a record transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      mbeats.delete();
      exp_q.delete();
      err_exp = 1'b0;
      held_v  = 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        bit frame_bad;
        frame_bad = 1'b0;
`ifdef NESTED_STRUCT_DESER_FRAME_CHECK_EN
        frame_bad = (s_last != (mbeats.size() == 2));
`endif
        if (frame_bad) begin
          err_exp = 1'b1;
          mbeats.delete();
        end else begin
          mbeats.push_back(s_data);
          if (mbeats.size() == 3) begin
            exp_q.push_back({mbeats[0], mbeats[1], mbeats[2]});
            mbeats.delete();
          end
        end
      end
      if (held_v) check("hold_stable", {8'h0, m_rec}, {8'h0, held_val});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {8'h0, m_rec}, 32'hFFFF_FFFF);
        else check("rec_out", {8'h0, m_rec}, {8'h0, exp_q.pop_front()});
        pops++;
      end
      held_v   = m_valid && !m_ready;
      held_val = m_rec;
    end
  end

  task automatic send_beat(input logic [7:0] b, input logic l);
    int   n;
    logic acc;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = l;
    n       = 0;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (ready_rand) m_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 32'(n), 32'(0));
    s_valid = 1'b0;
    if (gap_rand) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        if (ready_rand) m_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int c0;
    int n;
    logic [23:0] w2;

    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b1;
    s2_valid = 1'b0;
    s2_data  = '0;
    s2_last  = 1'b0;
    m2_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_rec", {8'h0, m_rec}, 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'(1));
    check("rst_err", 32'(err), 32'(0));

    // Single record, latency and field layout.
    send_beat(8'hA5, 1'b0);
    send_beat(8'h3C, 1'b0);
    send_beat(8'h7E, 1'b1);
    check("t1_valid", 32'(m_valid), 32'(1));
    check("t1_rec", {8'h0, m_rec}, 32'h00A5_3C7E);
    check("t1_flag", 32'(m_rec[23]), 32'(1));
    check("t1_kind", 32'(m_rec[22:20]), 32'(2));
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: second record collects behind a held first record.
    m_ready = 1'b0;
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    send_beat(8'h56, 1'b1);
    send_beat(8'hAB, 1'b0);
    send_beat(8'hCD, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hEF;
    s_last  = 1'b1;
    @(negedge clk);
    check("t2_stall", 32'(s_ready), 32'(0));
    check("t2_hold", {8'h0, m_rec}, 32'h0012_3456);
    @(posedge clk);
    #1;
    p0      = pops;
    m_ready = 1'b1;
    send_beat(8'hEF, 1'b1);
    check("t2_no_bubble", 32'(m_valid), 32'(1));
    check("t2_second", {8'h0, m_rec}, 32'h00AB_CDEF);
    repeat (2) @(posedge clk);
    #1;
    check("t2_pops", 32'(pops - p0), 32'(2));

    // Continuous stream: twelve beats in twelve cycles, four records out.
    c0 = cyc;
    p0 = pops;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 3; b++) send_beat(8'($urandom), b == 2);
    end
    check("t3_cycles", 32'(cyc - c0), 32'(12));
    repeat (2) @(posedge clk);
    #1;
    check("t3_pops", 32'(pops - p0), 32'(4));

    // Reset drops a pending record and a partial one.
    m_ready = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    send_beat(8'h44, 1'b0);
    send_beat(8'h55, 1'b0);
    pulse_reset();
    check("t4_rst_valid", 32'(m_valid), 32'(0));
    check("t4_rst_ready", 32'(s_ready), 32'(1));
    m_ready = 1'b1;
    p0      = pops;
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h01, 1'b1);
    check("t4_rec", {8'h0, m_rec}, 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;
    check("t4_pops", 32'(pops - p0), 32'(1));

`ifdef NESTED_STRUCT_DESER_FRAME_CHECK_EN
    // Early s_last ends a bad frame; the next clean record still lands.
    check("fc_err0", 32'(err), 32'(0));
    p0 = pops;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b1);
    check("fc_err1", 32'(err), 32'(1));
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b1);
    check("fc_rec", {8'h0, m_rec}, 32'h0001_0203);
    repeat (3) @(posedge clk);
    #1;
    check("fc_pops", 32'(pops - p0), 32'(1));
    check("fc_sticky", 32'(err), 32'(1));
    pulse_reset();
    check("fc_err_rst", 32'(err), 32'(0));
`endif

    // Randomized traffic with random backpressure, gaps and occasional bad s_last.
    ready_rand = 1'b1;
    gap_rand   = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int b = 0; b < 3; b++) begin
        logic l;
        l = (b == 2);
        if ($urandom_range(0, 9) == 0) l = ~l;
        send_beat(8'($urandom), l);
      end
    end
    ready_rand = 1'b0;
    gap_rand   = 1'b0;
    m_ready    = 1'b1;
    n          = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    check("err_model", 32'(err), 32'(err_exp));

    // Padded final beat on the narrow-payload instance.
    w2       = {8'hF1, 8'h23, 8'h4F};
    s2_valid = 1'b1;
    s2_data  = 8'hF1;
    s2_last  = 1'b0;
    check("p_ready", 32'(s2_ready), 32'(1));
    @(posedge clk);
    #1;
    s2_data = 8'h23;
    @(posedge clk);
    #1;
    s2_data = 8'h4F;
    s2_last = 1'b1;
    @(posedge clk);
    #1;
    s2_valid = 1'b0;
    check("p_valid", 32'(m2_valid), 32'(1));
    check("p_rec", {12'h0, m2_rec}, {12'h0, w2[23:4]});
    check("p_err", 32'(err2), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nested_struct_deser.md
Name: nested_struct_deser

Overview:
- Receiver end of the nested-struct record link; the transmit side packs an outer record (an inner header struct nested inside an outer struct) into fixed-width beats.
- This block collects beats MSB-first, reassembles one packed outer record, and presents it on a registered valid/ready output.
- It sits between a narrow beat channel and the record consumer, with one record of output buffering.

Parameters:
- BEAT_W, 8, width of one input beat in bits.
- PAYLOAD_W, 20, width of the outer record's data field; record width REC_W = HDR_W + PAYLOAD_W, with HDR_W = 4 from the package.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  BEAT_W  input beat, record bits MSB-first.
- s_last  in  1  marks the last beat of a record; used only with the optional feature.
- m_valid  out  1  output record valid.
- m_ready  in  1  output record ready.
- m_rec  out  REC_W  reassembled outer record: {hdr.flag, hdr.kind[2:0], data[PAYLOAD_W-1:0]}.
- err  out  1  sticky framing error; tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values: m_valid=0, m_rec=0, err=0, beat count=0, shift register=0. s_ready=1 from the first cycle after reset.
- Record length: NBEATS = ceil(REC_W/BEAT_W).
  - Defaults give REC_W=24, NBEATS=3.
  - If REC_W is not a multiple of BEAT_W, the low (NBEATS*BEAT_W - REC_W) bits of the final beat are padding and are discarded.
- Handshake: a beat transfers when s_valid && s_ready; a record transfers when m_valid && m_ready. Each beat shifts into the accumulator, MSB-first.
- Beat counter wraps:
  - Counter cnt runs 0..NBEATS-1.
  - The final beat (cnt==NBEATS-1) resets cnt to 0 and loads m_rec from {accumulator, beat} in the same edge.
  - m_valid rises the cycle after the final beat transfers (latency 1 cycle from final beat).
- States:
  - COLLECT: cnt < NBEATS-1.
  - LAST: cnt == NBEATS-1.
  - Output register FULL/EMPTY tracked by m_valid.
- s_ready = !(cnt==NBEATS-1 && m_valid && !m_ready).
  - Non-final beats are always accepted, so the next record is collected while the previous one is held.
  - The final beat stalls only while the output is full and not draining.
- Simultaneous events: final beat and m_ready in the same cycle → the old record leaves, the new record loads, and m_valid stays 1 with no bubble.
- m_valid && !m_ready: m_rec holds stable; it must not change until accepted.
- s_valid deasserted mid-record: the partial record is held indefinitely; no timeout.
- Reset mid-record: the partial record is discarded and any pending output is dropped (m_valid=0).

Optional Feature:
- Macro: NESTED_STRUCT_DESER_FRAME_CHECK_EN.
- With the macro:
  - s_last is checked on every accepted beat; a mismatch is s_last=1 when cnt!=NBEATS-1, or s_last=0 when cnt==NBEATS-1.
  - A mismatch sets err (sticky until reset) and resyncs: cnt→0, the accumulated beats are discarded, and no record is emitted for that beat.
  - If s_last=1 arrives early, that beat ends the bad frame.
- Without the macro: s_last is ignored and err is constant 0.

Decomposition:
- Package nested_struct_pkg holds:
  - inner_t (packed: flag, kind[2:0]) and HDR_W=4.
  - outer_t template fields (hdr inner_t, data).
  - Helper constant function for NBEATS.
- One sub-module is natural: nested_struct_out_reg, a one-entry valid/ready holding register for m_rec/m_valid.
- The beat counter, accumulator and frame check stay in the top.

Test Plan:
- Defaults, beats 0xA5, 0x3C, 0x7E with m_ready=1 → one cycle after the third beat, m_valid=1 and m_rec=0xA53C7E (flag=1, kind=2, data=0x53C7E).
- m_ready=0, send two back-to-back records 0x123456 and 0xABCDEF:
  - The first is held; beats 0xAB and 0xCD are accepted; s_ready=0 at beat 0xEF.
  - Raising m_ready delivers 0x123456, then 0xABCDEF, in order.
- Continuous stream of 4 records with m_ready=1 → 4 outputs, one every 3 cycles, and s_ready never drops.
- Reset (rst_n=0 for 1 cycle) after 2 beats, then send 0x000001 → only 0x000001 emerges; the partial record is lost.
- BEAT_W=8, PAYLOAD_W=16 (REC_W=20, NBEATS=3), beats 0xF1, 0x23, 0x4F → m_rec=0xF1234 and padding 0xF is dropped.
- With the frame-check macro, s_last=1 on the second beat → err=1 and no output.
  - The next clean 3-beat record 0x010203 is still delivered correctly.
  - err stays 1 until reset.
